// File: rtl/osd_dem_uart_axil_bridge.sv
// AXI4-Lite slave to 8-bit register-bus bridge with one-entry AW/W holding buffers,
// read/write round-robin arbitration, out-of-range checking and a bus-ack timeout.
module osd_dem_uart_axil_bridge #(
   parameter int unsigned ID_WIDTH        = 1,
   parameter int unsigned ADDR_WIDTH      = 5,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned REG_STRIDE_LOG2 = 2,
   parameter int unsigned TIMEOUT         = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ID_WIDTH-1:0]     aw_id,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_valid,
   output logic                    w_ready,
   output logic [ID_WIDTH-1:0]     b_id,
   output logic [1:0]              b_resp,
   output logic                    b_valid,
   input  logic                    b_ready,
   input  logic [ID_WIDTH-1:0]     ar_id,
   input  logic [ADDR_WIDTH-1:0]   ar_addr,
   input  logic                    ar_valid,
   output logic                    ar_ready,
   output logic [ID_WIDTH-1:0]     r_id,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [1:0]              r_resp,
   output logic                    r_valid,
   input  logic                    r_ready,
   output logic                    bus_req,
   output logic                    bus_write,
   output logic [2:0]              bus_addr,
   output logic [7:0]              bus_wdata,
   input  logic                    bus_ack,
   input  logic [7:0]              bus_rdata
);

   localparam int unsigned IDX_LSB = REG_STRIDE_LOG2;
   localparam int unsigned IDX_HI  = REG_STRIDE_LOG2 + 3;
   localparam int unsigned CNT_W   = 16;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP_R, S_RESP_B} state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_alive;
   logic                    r_aw_full, w_aw_full_nxt, r_aw_ready;
   logic                    r_w_full, w_w_full_nxt, r_w_ready;
   logic [ID_WIDTH-1:0]     r_aw_id;
   logic [ADDR_WIDTH-1:0]   r_aw_addr;
   logic [7:0]              r_w_data;
   logic                    r_w_strb0;
   logic                    r_last_write, w_last_write_nxt;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic                    r_bus_req, w_bus_req_nxt;
   logic                    r_bus_write, w_bus_write_nxt;
   logic [2:0]              r_bus_addr, w_bus_addr_nxt;
   logic [7:0]              r_bus_wdata, w_bus_wdata_nxt;
   logic [ID_WIDTH-1:0]     r_rid, w_rid_nxt, r_bid, w_bid_nxt;
   logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
   logic [1:0]              r_rresp, w_rresp_nxt, r_bresp, w_bresp_nxt;
   logic                    r_rvalid, w_rvalid_nxt, r_bvalid, w_bvalid_nxt;

   logic                    w_aw_hs, w_w_hs, w_wr_pend, w_sel_wr, w_sel_rd;
   logic [ADDR_WIDTH-1:0]   w_req_addr;
   logic [2:0]              w_req_idx;
   logic                    w_req_oor;
   logic                    w_unused;

   assign w_aw_hs    = aw_valid & r_aw_ready;
   assign w_w_hs     = w_valid & r_w_ready;
   assign w_wr_pend  = r_aw_full & r_w_full;
   // Write wins a tie unless the previous completed transaction was a write.
   assign w_sel_wr   = (r_state == S_IDLE) & w_wr_pend & (~ar_valid | ~r_last_write);
   assign w_sel_rd   = (r_state == S_IDLE) & r_alive & ar_valid & (~w_wr_pend | r_last_write);
   assign w_req_addr = w_sel_wr ? r_aw_addr : ar_addr;
   assign w_req_idx  = 3'(w_req_addr >> IDX_LSB);
   assign w_req_oor  = |(w_req_addr >> IDX_HI);
   assign w_unused   = ^{w_data, w_strb};

   assign aw_ready  = r_aw_ready;
   assign w_ready   = r_w_ready;
   assign ar_ready  = w_sel_rd;
   assign b_id      = r_bid;
   assign b_resp    = r_bresp;
   assign b_valid   = r_bvalid;
   assign r_id      = r_rid;
   assign r_data    = r_rdata;
   assign r_resp    = r_rresp;
   assign r_valid   = r_rvalid;
   assign bus_req   = r_bus_req;
   assign bus_write = r_bus_write;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_aw_full_nxt    = r_aw_full;
      w_w_full_nxt     = r_w_full;
      w_last_write_nxt = r_last_write;
      w_cnt_nxt        = r_cnt;
      w_bus_req_nxt    = r_bus_req;
      w_bus_write_nxt  = r_bus_write;
      w_bus_addr_nxt   = r_bus_addr;
      w_bus_wdata_nxt  = r_bus_wdata;
      w_rid_nxt        = r_rid;
      w_bid_nxt        = r_bid;
      w_rdata_nxt      = r_rdata;
      w_rresp_nxt      = r_rresp;
      w_bresp_nxt      = r_bresp;
      w_rvalid_nxt     = r_rvalid;
      w_bvalid_nxt     = r_bvalid;

      if (w_aw_hs) w_aw_full_nxt = 1'b1;
      if (w_w_hs)  w_w_full_nxt  = 1'b1;

      case (r_state)
         S_IDLE: begin
            if (w_sel_wr) begin
               w_aw_full_nxt = 1'b0;
               w_w_full_nxt  = 1'b0;
               w_bid_nxt     = r_aw_id;
               if (w_req_oor) begin
                  w_bresp_nxt  = RESP_SLVERR;
                  w_bvalid_nxt = 1'b1;
                  w_state_nxt  = S_RESP_B;
               end else if (!r_w_strb0) begin
                  w_bresp_nxt  = RESP_OKAY;
                  w_bvalid_nxt = 1'b1;
                  w_state_nxt  = S_RESP_B;
               end else begin
                  w_bus_req_nxt   = 1'b1;
                  w_bus_write_nxt = 1'b1;
                  w_bus_addr_nxt  = w_req_idx;
                  w_bus_wdata_nxt = r_w_data;
                  w_cnt_nxt       = '0;
                  w_state_nxt     = S_BUS;
               end
            end else if (w_sel_rd) begin
               w_rid_nxt = ar_id;
               if (w_req_oor) begin
                  w_rresp_nxt  = RESP_SLVERR;
                  w_rdata_nxt  = '0;
                  w_rvalid_nxt = 1'b1;
                  w_state_nxt  = S_RESP_R;
               end else begin
                  w_bus_req_nxt   = 1'b1;
                  w_bus_write_nxt = 1'b0;
                  w_bus_addr_nxt  = w_req_idx;
                  w_cnt_nxt       = '0;
                  w_state_nxt     = S_BUS;
               end
            end
         end
         S_BUS: begin
            // An ack in the final counted cycle still completes normally.
            if (bus_ack || (r_cnt == CNT_W'(TIMEOUT - 1))) begin
               w_bus_req_nxt = 1'b0;
               if (r_bus_write) begin
                  w_bresp_nxt  = bus_ack ? RESP_OKAY : RESP_DECERR;
                  w_bvalid_nxt = 1'b1;
                  w_state_nxt  = S_RESP_B;
               end else begin
                  w_rresp_nxt  = bus_ack ? RESP_OKAY : RESP_DECERR;
                  w_rdata_nxt  = bus_ack ? DATA_WIDTH'(bus_rdata) : '0;
                  w_rvalid_nxt = 1'b1;
                  w_state_nxt  = S_RESP_R;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_RESP_R: begin
            if (r_ready) begin
               w_rvalid_nxt     = 1'b0;
               w_last_write_nxt = 1'b0;
               w_state_nxt      = S_IDLE;
            end
         end
         S_RESP_B: begin
            if (b_ready) begin
               w_bvalid_nxt     = 1'b0;
               w_last_write_nxt = 1'b1;
               w_state_nxt      = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_alive      <= 1'b0;
         r_aw_full    <= 1'b0;
         r_w_full     <= 1'b0;
         r_aw_ready   <= 1'b0;
         r_w_ready    <= 1'b0;
         r_aw_id      <= '0;
         r_aw_addr    <= '0;
         r_w_data     <= '0;
         r_w_strb0    <= 1'b0;
         r_last_write <= 1'b0;
         r_cnt        <= '0;
         r_bus_req    <= 1'b0;
         r_bus_write  <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_wdata  <= '0;
         r_rid        <= '0;
         r_bid        <= '0;
         r_rdata      <= '0;
         r_rresp      <= '0;
         r_bresp      <= '0;
         r_rvalid     <= 1'b0;
         r_bvalid     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_alive      <= 1'b1;
         r_aw_full    <= w_aw_full_nxt;
         r_w_full     <= w_w_full_nxt;
         r_aw_ready   <= ~w_aw_full_nxt;
         r_w_ready    <= ~w_w_full_nxt;
         if (w_aw_hs) begin
            r_aw_id   <= aw_id;
            r_aw_addr <= aw_addr;
         end
         if (w_w_hs) begin
            r_w_data  <= w_data[7:0];
            r_w_strb0 <= w_strb[0];
         end
         r_last_write <= w_last_write_nxt;
         r_cnt        <= w_cnt_nxt;
         r_bus_req    <= w_bus_req_nxt;
         r_bus_write  <= w_bus_write_nxt;
         r_bus_addr   <= w_bus_addr_nxt;
         r_bus_wdata  <= w_bus_wdata_nxt;
         r_rid        <= w_rid_nxt;
         r_bid        <= w_bid_nxt;
         r_rdata      <= w_rdata_nxt;
         r_rresp      <= w_rresp_nxt;
         r_bresp      <= w_bresp_nxt;
         r_rvalid     <= w_rvalid_nxt;
         r_bvalid     <= w_bvalid_nxt;
      end
   end

endmodule

// File: tb/tb_osd_dem_uart_axil_bridge.sv
// Directed bench for osd_dem_uart_axil_bridge: a vector table of single transactions
// plus hand sequences for reset, response hold, arbitration and mid-transaction reset.
module tb_osd_dem_uart_axil_bridge;

   logic        clk, rst;
   logic [0:0]  aw_id, ar_id, b_id, r_id;
   logic [7:0]  aw_addr, ar_addr;
   logic        aw_valid, aw_ready, w_valid, w_ready, ar_valid, ar_ready;
   logic [31:0] w_data, r_data;
   logic [3:0]  w_strb;
   logic [1:0]  b_resp, r_resp;
   logic        b_valid, b_ready, r_valid, r_ready;
   logic        bus_req, bus_write, bus_ack;
   logic [2:0]  bus_addr;
   logic [7:0]  bus_wdata, bus_rdata;

   osd_dem_uart_axil_bridge #(
      .ID_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(32), .REG_STRIDE_LOG2(2), .TIMEOUT(10)
   ) dut (
      .clk(clk), .rst(rst),
      .aw_id(aw_id), .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
      .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .ar_id(ar_id), .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
      .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Register-bus responder: acks ack_delay cycles into a request (never if negative).
   int         ack_delay = 0;
   logic [7:0] ack_rdata = 8'h00;
   int         bus_starts = 0, req_len = 0, wait_cnt = 0, unstable = 0;
   logic [2:0] cap_addr;
   logic [7:0] cap_wdata;
   logic       cap_write, prev_req = 1'b0;
   bit         order[$];

   initial begin
      bus_ack = 1'b0;
      bus_rdata = 8'h00;
      forever begin
         @(negedge clk);
         bus_ack = 1'b0;
         if (bus_req) begin
            if (!prev_req) begin
               bus_starts++;
               cap_addr = bus_addr; cap_wdata = bus_wdata; cap_write = bus_write;
               order.push_back(bus_write);
               req_len = 0; wait_cnt = 0;
            end else if (bus_addr !== cap_addr || bus_wdata !== cap_wdata || bus_write !== cap_write) begin
               unstable++;
            end
            req_len++;
            if (ack_delay >= 0 && wait_cnt == ack_delay) begin
               bus_ack = 1'b1;
               bus_rdata = ack_rdata;
            end
            wait_cnt++;
         end
         prev_req = bus_req;
      end
   end

   // Present the selected channels from a falling edge; returns on the falling edge after the last handshake.
   task automatic send(input bit do_aw, input bit do_w, input bit do_ar, input logic [0:0] id,
                       input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit aw_go, w_go, ar_go;
      int guard = 0;
      if (do_aw) begin aw_valid = 1'b1; aw_id = id; aw_addr = addr; end
      if (do_w)  begin w_valid = 1'b1; w_data = data; w_strb = strb; end
      if (do_ar) begin ar_valid = 1'b1; ar_id = id; ar_addr = addr; end
      while ((aw_valid || w_valid || ar_valid) && guard < 100) begin
         #1;
         aw_go = aw_valid && aw_ready;
         w_go  = w_valid && w_ready;
         ar_go = ar_valid && ar_ready;
         @(negedge clk);
         if (aw_go) aw_valid = 1'b0;
         if (w_go)  w_valid  = 1'b0;
         if (ar_go) ar_valid = 1'b0;
         guard++;
      end
      if (guard >= 100) begin
         n_checks++; n_fail++;
         $display("FAIL handshake: no ready within 100 cycles, required a handshake");
         aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      end
   endtask

   typedef struct {
      bit          is_wr;
      logic [0:0]  id;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          w_gap;
      int          delay;
      logic [7:0]  rdata;
      bit          exp_bus;
      logic [2:0]  exp_baddr;
      logic [7:0]  exp_bwdata;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t tbl[9];

   task automatic do_txn(input vec_t v, input int k);
      int s0, lat, exp_len;
      ack_delay = v.delay;
      ack_rdata = v.rdata;
      s0 = bus_starts;
      if (v.is_wr) begin
         if (v.w_gap > 0) begin
            send(1'b0, 1'b1, 1'b0, v.id, v.addr, v.wdata, v.strb);
            repeat (v.w_gap) @(negedge clk);
            send(1'b1, 1'b0, 1'b0, v.id, v.addr, v.wdata, v.strb);
         end else begin
            send(1'b1, 1'b1, 1'b0, v.id, v.addr, v.wdata, v.strb);
         end
      end else begin
         send(1'b0, 1'b0, 1'b1, v.id, v.addr, 32'h0, 4'h0);
      end
      lat = 1;
      while (!(v.is_wr ? b_valid : r_valid) && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d_latency", k), lat, v.exp_lat);
      chk($sformatf("v%0d_bus_cycles", k), bus_starts - s0, v.exp_bus ? 1 : 0);
      if (v.is_wr) begin
         chk($sformatf("v%0d_b_resp", k), b_resp, v.exp_resp);
         chk($sformatf("v%0d_b_id", k), b_id, v.id);
      end else begin
         chk($sformatf("v%0d_r_resp", k), r_resp, v.exp_resp);
         chk($sformatf("v%0d_r_id", k), r_id, v.id);
         chk($sformatf("v%0d_r_data", k), r_data, v.exp_rdata);
      end
      if (v.exp_bus) begin
         exp_len = (v.delay < 0) ? 10 : v.delay + 1;
         chk($sformatf("v%0d_bus_addr", k), cap_addr, v.exp_baddr);
         chk($sformatf("v%0d_bus_write", k), cap_write, v.is_wr);
         chk($sformatf("v%0d_bus_req_len", k), req_len, exp_len);
         if (v.is_wr) chk($sformatf("v%0d_bus_wdata", k), cap_wdata, v.exp_bwdata);
      end
      if (v.is_wr) b_ready = 1'b1; else r_ready = 1'b1;
      @(negedge clk);
      b_ready = 1'b0; r_ready = 1'b0;
      chk($sformatf("v%0d_valid_drop", k), v.is_wr ? b_valid : r_valid, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int lat, seen, guard, aw_n, w_n, ar_n, s0;
      bit aw_go, w_go, ar_go;
      bit exp_order[4];

      //               wr  id    addr   wdata         strb gap dly  rdata  bus  baddr bwdata resp   rdata          lat
      tbl[0] = '{1'b1, 1'b1, 8'h04, 32'h0000_0041, 4'hF, 3,  2, 8'h00, 1'b1, 3'd1, 8'h41, 2'b00, 32'h0,          5};
      tbl[1] = '{1'b0, 1'b0, 8'h14, 32'h0,         4'h0, 0,  0, 8'h5A, 1'b1, 3'd5, 8'h00, 2'b00, 32'h0000_005A,  2};
      tbl[2] = '{1'b0, 1'b1, 8'h20, 32'h0,         4'h0, 0,  0, 8'h77, 1'b0, 3'd0, 8'h00, 2'b10, 32'h0,          1};
      tbl[3] = '{1'b1, 1'b0, 8'h1C, 32'h1234_5678, 4'h1, 0,  1, 8'h00, 1'b1, 3'd7, 8'h78, 2'b00, 32'h0,          4};
      tbl[4] = '{1'b1, 1'b1, 8'h08, 32'h0000_00AA, 4'hE, 0,  0, 8'h00, 1'b0, 3'd0, 8'h00, 2'b00, 32'h0,          2};
      tbl[5] = '{1'b1, 1'b0, 8'h40, 32'h0000_00BB, 4'hF, 0,  0, 8'h00, 1'b0, 3'd0, 8'h00, 2'b10, 32'h0,          2};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 32'h0,         4'h0, 0,  9, 8'hC3, 1'b1, 3'd0, 8'h00, 2'b00, 32'h0000_00C3, 11};
      tbl[7] = '{1'b0, 1'b1, 8'h0C, 32'h0,         4'h0, 0, -1, 8'h00, 1'b1, 3'd3, 8'h00, 2'b11, 32'h0,         11};
      tbl[8] = '{1'b0, 1'b0, 8'h10, 32'h0,         4'h0, 0,  3, 8'hFF, 1'b1, 3'd4, 8'h00, 2'b00, 32'h0000_00FF,  5};

      rst = 1'b0;
      aw_valid = 1'b0; aw_id = '0; aw_addr = '0;
      w_valid = 1'b0; w_data = '0; w_strb = '0;
      ar_valid = 1'b1; ar_id = '0; ar_addr = '0;
      b_ready = 1'b0; r_ready = 1'b0;

      // Reset state, with a read already presented.
      repeat (2) @(negedge clk);
      chk("rst_aw_ready", aw_ready, 1'b0);
      chk("rst_w_ready", w_ready, 1'b0);
      chk("rst_ar_ready", ar_ready, 1'b0);
      chk("rst_r_valid", r_valid, 1'b0);
      chk("rst_b_valid", b_valid, 1'b0);
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_r_data", r_data, 32'h0);
      ar_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_aw_ready", aw_ready, 1'b1);
      chk("post_rst_w_ready", w_ready, 1'b1);

      for (int i = 0; i < 9; i++) do_txn(tbl[i], i);

      // Response held while r_ready stays low.
      ack_delay = 5; ack_rdata = 8'hA5;
      send(1'b0, 1'b0, 1'b1, 1'b1, 8'h14, 32'h0, 4'h0);
      lat = 1;
      while (!r_valid && lat < 100) begin @(negedge clk); lat++; end
      chk("hold_latency", lat, 7);
      chk("hold_r_data", r_data, 32'h0000_00A5);
      chk("hold_r_resp", r_resp, 2'b00);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("hold_r_valid_c%0d", c), r_valid, 1'b1);
         chk($sformatf("hold_r_data_c%0d", c), r_data, 32'h0000_00A5);
      end
      r_ready = 1'b1;
      @(negedge clk);
      r_ready = 1'b0;
      chk("hold_release", r_valid, 1'b0);

      // Arbitration: write pending and read presented together, twice.
      do_reset();
      order.delete();
      ack_delay = 0; b_ready = 1'b1; r_ready = 1'b1;
      s0 = bus_starts;
      aw_valid = 1'b1; aw_id = 1'b0; aw_addr = 8'h04;
      w_valid = 1'b1; w_data = 32'h11; w_strb = 4'hF;
      ar_id = 1'b1; ar_addr = 8'h0C;
      aw_n = 0; w_n = 0; ar_n = 0; guard = 0;
      while ((aw_n < 2 || w_n < 2 || ar_n < 2) && guard < 200) begin
         #1;
         aw_go = aw_valid && aw_ready;
         w_go  = w_valid && w_ready;
         ar_go = ar_valid && ar_ready;
         @(negedge clk);
         guard++;
         if (aw_go) begin aw_n++; aw_addr = 8'h08; if (aw_n >= 2) aw_valid = 1'b0; end
         if (w_go)  begin w_n++; w_data = 32'h22; if (w_n >= 2) w_valid = 1'b0; end
         if (ar_go) ar_n++;
         ar_valid = (ar_n < 2) && (aw_n >= 1);
      end
      repeat (20) @(negedge clk);
      b_ready = 1'b0; r_ready = 1'b0;
      chk("arb_guard", guard < 200, 1'b1);
      chk("arb_bus_cycles", bus_starts - s0, 4);
      exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
      chk("arb_order_len", order.size(), 4);
      if (order.size() == 4)
         for (int i = 0; i < 4; i++) chk($sformatf("arb_order_%0d", i), order[i], exp_order[i]);

      // Reset asserted mid bus cycle.
      ack_delay = -1;
      send(1'b0, 1'b0, 1'b1, 1'b1, 8'h0C, 32'h0, 4'h0);
      chk("abort_bus_req_pre", bus_req, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("abort_bus_req_async", bus_req, 1'b0);
      chk("abort_aw_ready", aw_ready, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (r_valid || b_valid) seen++;
      end
      chk("abort_no_response", seen, 0);
      do_txn(tbl[1], 100);
      do_txn(tbl[3], 103);

      chk("bus_signals_stable", unstable, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/osd_dem_uart_axil_bridge.md
OSD_DEM_UART_AXIL_BRIDGE -- requirements
Module: osd_dem_uart_axil_bridge

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 1, meaning the width of the AXI ID fields echoed back in responses.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning the width of the AXI byte address.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning the AXI data width; legal values are 8, 32 and 64.
REQ-004 The block SHALL have parameter REG_STRIDE_LOG2, default 2, meaning log2 of the byte spacing between registers.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a bus_req may wait for bus_ack; legal values are 1 to 65535.
REQ-006 The block SHALL have the following ports, one per line (name, direction, width, meaning):
 clk  in  1  the single clock; all logic is on the rising edge
 rst  in  1  asynchronous, active-low reset
 aw_id/aw_addr/aw_valid  in  ID_WIDTH/ADDR_WIDTH/1  write-address channel
 aw_ready  out  1  write-address channel ready
 w_data/w_strb/w_valid  in  DATA_WIDTH/DATA_WIDTH/8/1  write-data channel
 w_ready  out  1  write-data channel ready
 b_id/b_resp/b_valid  out  ID_WIDTH/2/1  write-response channel
 b_ready  in  1  write-response channel ready
 ar_id/ar_addr/ar_valid  in  ID_WIDTH/ADDR_WIDTH/1  read-address channel
 ar_ready  out  1  read-address channel ready
 r_id/r_data/r_resp/r_valid  out  ID_WIDTH/DATA_WIDTH/2/1  read-data channel
 r_ready  in  1  read-data channel ready
 bus_req/bus_write  out  1/1  register-bus request and direction
 bus_addr  out  3  register index
 bus_wdata  out  8  register write data
 bus_ack  in  1  register-bus acknowledge
 bus_rdata  in  8  register read data, valid with bus_ack

Function
REQ-007 The AW and W channels SHALL each have an independent one-entry holding buffer; aw_ready = AW buffer empty and w_ready = W buffer empty, so AW and W may arrive in either order or in different cycles.
REQ-008 A write SHALL be pending when both holding buffers are full; both buffers SHALL be emptied when the write is dispatched.
REQ-009 The block SHALL have four states: IDLE, BUS, RESP_R and RESP_B.
REQ-010 In IDLE, when a write is pending and ar_valid is high in the same cycle, the block SHALL serve the type not served last; a last_write flag, reset to 0, SHALL make the write win first after reset.
REQ-011 ar_ready SHALL be high only in IDLE when the read is the selected request; the read handshake SHALL take effect in that same cycle.
REQ-012 The register index SHALL be addr[REG_STRIDE_LOG2+2:REG_STRIDE_LOG2].
REQ-013 If any address bit above the register index is nonzero, the request SHALL be out of range.
REQ-014 An out-of-range request SHALL issue no bus cycle; the block SHALL go directly to RESP_R or RESP_B with resp=2'b10 (SLVERR) and r_data=0.
REQ-015 A write whose w_strb[0] is 0 SHALL issue no bus cycle and SHALL respond OKAY.
REQ-016 For an in-range request, the block SHALL enter BUS, driving bus_req=1 together with bus_addr, bus_write and bus_wdata=w_data[7:0]; these signals SHALL be held stable until exit from BUS.
REQ-017 On bus_ack in BUS, the block SHALL drop bus_req in the next cycle, capture r_data = {zeros, bus_rdata} (reads only), set resp=2'b00 and enter RESP_R or RESP_B.
REQ-018 Minimum latency SHALL be 1 cycle from the accepting handshake to bus_req, and 1 cycle from bus_ack to r_valid/b_valid.
REQ-019 A cycle counter SHALL run in BUS; if it reaches TIMEOUT with no bus_ack, the block SHALL drop bus_req and respond 2'b11 (DECERR) with r_data=0.
REQ-020 A bus_ack arriving in the same cycle the counter reaches TIMEOUT SHALL take priority over the timeout.
REQ-021 In RESP_R, r_valid=1 and r_id equals the captured ar_id; in RESP_B, b_valid=1 and b_id equals the captured aw_id.
REQ-022 The block SHALL leave RESP_R or RESP_B for IDLE on r_ready or b_ready respectively, and SHALL update last_write at that point.
REQ-023 Response outputs SHALL hold stable while valid and not ready.
REQ-024 bus_ack outside BUS SHALL be ignored.
REQ-025 While in RESP_B, the AW and W buffers SHALL still accept the next write.

Reset
REQ-026 Asserting rst low at any time, including mid-transaction, SHALL immediately force: state=IDLE; both buffers empty; last_write=0; counter=0; bus_req=0; and aw_ready, w_ready, ar_ready, r_valid, b_valid, r_data, r_resp, b_resp, r_id, b_id all 0. No response SHALL be generated for an aborted transaction.
REQ-027 After rst deasserts, aw_ready and w_ready SHALL be 1 on the first clock edge.

Verification
REQ-028 W sent 3 cycles before AW (addr=0x04, data=0x41, strb=0xF, id=1) -> exactly one bus write with bus_addr=1 and bus_wdata=0x41; then b_valid with b_id=1 and b_resp=0.
REQ-029 Read addr=0x14 with bus_rdata=0xA5 acked after 5 cycles -> r_data=0x000000A5, r_resp=0; r_valid is held for 4 cycles while r_ready=0.
REQ-030 Read addr=0x20 (out of range) -> no bus_req; r_resp=2'b10; r_data=0.
REQ-031 bus_ack never asserted, TIMEOUT=10 -> bus_req drops after 10 cycles; r_resp=2'b11; a later read completes normally.
REQ-032 Write pending and read presented together, twice back-to-back -> service order is write, read, write, read.
REQ-033 rst asserted during BUS -> bus_req goes to 0 asynchronously; no r_valid or b_valid follows; the next transaction completes correctly.
